// File: rtl/rd_c2h_packer.sv
// Packs PHY read-return beats into AXI-Stream C2H packets through a non-back-pressurable FIFO,
// with flush/idle-timeout early termination and debug counters.
module rd_c2h_packer #(
   parameter int unsigned DATA_WIDTH = 512,
   parameter int unsigned FIFO_DEPTH = 64,
   parameter int unsigned PKT_BEATS  = 16,
   parameter int unsigned IDLE_FLUSH = 256
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [DATA_WIDTH-1:0]       rd_data,
   input  logic                        rd_valid,
   input  logic                        flush,
   output logic [DATA_WIDTH-1:0]       M_AXIS_C2H_tdata,
   output logic                        M_AXIS_C2H_tvalid,
   input  logic                        M_AXIS_C2H_tready,
   output logic [DATA_WIDTH/8-1:0]     M_AXIS_C2H_tkeep,
   output logic                        M_AXIS_C2H_tlast,
   output logic [$clog2(FIFO_DEPTH):0] fifo_count,
   output logic [15:0]                 drop_count,
   output logic [31:0]                 pkt_count,
   output logic                        overflow
);

   localparam int unsigned AW        = $clog2(FIFO_DEPTH);
   localparam int unsigned CW        = AW + 1;
   localparam int unsigned BW        = (PKT_BEATS > 1) ? $clog2(PKT_BEATS) : 1;
   localparam int unsigned IW        = (IDLE_FLUSH > 1) ? $clog2(IDLE_FLUSH) : 1;
   localparam int unsigned IDLE_LAST = (IDLE_FLUSH > 0) ? IDLE_FLUSH - 1 : 0;

   logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];

   logic [AW-1:0] wr_ptr, wr_ptr_nxt;
   logic [AW-1:0] rd_ptr, rd_ptr_nxt;
   logic [CW-1:0] count_nxt;
   logic [BW-1:0] beat_idx, beat_idx_nxt;
   logic          flush_pend, flush_pend_nxt;
   logic [IW-1:0] idle_cnt, idle_cnt_nxt;
   logic [15:0]   drop_count_nxt;
   logic [31:0]   pkt_count_nxt;
   logic          overflow_nxt;

   logic cnt_zero, cnt_one, cnt_ge2, full, at_last_beat;
   logic tvalid_c, tlast_c, wr_en, drop, xfer, idle_fire;

   // Next-state and output decode; the final FIFO entry is withheld until its packet role is known.
   always_comb begin
      cnt_zero       = (fifo_count == '0);
      cnt_one        = (fifo_count == CW'(1));
      cnt_ge2        = !cnt_zero && !cnt_one;
      full           = (fifo_count == CW'(FIFO_DEPTH));
      at_last_beat   = (beat_idx == BW'(PKT_BEATS - 1));

      tvalid_c       = cnt_ge2 || (cnt_one && (at_last_beat || flush_pend));
      tlast_c        = tvalid_c && (at_last_beat || (flush_pend && cnt_one));
      xfer           = tvalid_c && M_AXIS_C2H_tready;
      wr_en          = rd_valid && !full;
      drop           = rd_valid && full;

      wr_ptr_nxt     = wr_ptr;
      rd_ptr_nxt     = rd_ptr;
      count_nxt      = fifo_count;
      beat_idx_nxt   = beat_idx;
      flush_pend_nxt = flush_pend;
      idle_cnt_nxt   = idle_cnt;
      idle_fire      = 1'b0;
      drop_count_nxt = drop_count;
      pkt_count_nxt  = pkt_count;
      overflow_nxt   = overflow;

      if (wr_en) begin
         wr_ptr_nxt = wr_ptr + AW'(1);
      end
      if (xfer) begin
         rd_ptr_nxt = rd_ptr + AW'(1);
      end

      case ({wr_en, xfer})
         2'b10:   count_nxt = fifo_count + CW'(1);
         2'b01:   count_nxt = fifo_count - CW'(1);
         default: count_nxt = fifo_count;
      endcase

      if (drop) begin
         overflow_nxt = 1'b1;
         if (drop_count != 16'hFFFF) begin
            drop_count_nxt = drop_count + 16'd1;
         end
      end

      if (xfer) begin
         if (tlast_c) begin
            beat_idx_nxt  = '0;
            pkt_count_nxt = pkt_count + 32'd1;
         end else begin
            beat_idx_nxt  = beat_idx + BW'(1);
         end
      end

      // Idle timer only runs while a beat sits withheld and nothing else is happening.
      if (IDLE_FLUSH != 0) begin
         if (rd_valid || xfer) begin
            idle_cnt_nxt = '0;
         end else if (!cnt_zero && !tvalid_c) begin
            if (idle_cnt == IW'(IDLE_LAST)) begin
               idle_cnt_nxt = '0;
               idle_fire    = 1'b1;
            end else begin
               idle_cnt_nxt = idle_cnt + IW'(1);
            end
         end
      end

      // A new flush request wins over the clear from a concurrent tlast, so it lands on the next packet.
      if (xfer && tlast_c) begin
         flush_pend_nxt = 1'b0;
      end
      if (flush_pend && cnt_zero && (beat_idx == '0)) begin
         flush_pend_nxt = 1'b0;
      end
      if (flush || idle_fire) begin
         flush_pend_nxt = 1'b1;
      end

      M_AXIS_C2H_tvalid = tvalid_c;
      M_AXIS_C2H_tlast  = tlast_c;
      M_AXIS_C2H_tkeep  = '1;
      M_AXIS_C2H_tdata  = tvalid_c ? mem[rd_ptr] : '0;
   end

   // Control and counter state.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
         beat_idx   <= '0;
         flush_pend <= 1'b0;
         idle_cnt   <= '0;
         drop_count <= '0;
         pkt_count  <= '0;
         overflow   <= 1'b0;
      end else begin
         wr_ptr     <= wr_ptr_nxt;
         rd_ptr     <= rd_ptr_nxt;
         fifo_count <= count_nxt;
         beat_idx   <= beat_idx_nxt;
         flush_pend <= flush_pend_nxt;
         idle_cnt   <= idle_cnt_nxt;
         drop_count <= drop_count_nxt;
         pkt_count  <= pkt_count_nxt;
         overflow   <= overflow_nxt;
      end
   end

   // Beat storage: unreset distributed RAM, read asynchronously at rd_ptr.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_ptr] <= rd_data;
      end
   end

endmodule
